icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache that answers the fetch stage's instruction requests. Each cycle it takes the fetch address and returns the instruction combinationally on a hit. On a miss it drives a stall into fetch and refills the whole line from main memory over a beat-per-word request/valid interface. It sits between the fetch stage's instruction-memory port and the memory system.

## Interface
- LINE_WORDS, 4, words per line; power of two, 2..16
- NUM_LINES, 64, number of lines; power of two
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- Instr_address_fIF  in  32  fetch address; bits [1:0] ignored
- Instr1_2IF  out  32  instruction at the fetch address; 32'h0 when not a hit
- Miss_STALL  out  1  high whenever the current address does not hit; drives fetch STALL
- Flush  in  1  one-cycle pulse; invalidates every line
- Mem_req  out  1  registered; high for the whole refill
- Mem_addr  out  32  registered line-aligned refill address; low log2(LINE_WORDS)+2 bits are zero
- Mem_data  in  32  refill word
- Mem_valid  in  1  one refill word per high cycle, delivered in ascending word order, only while Mem_req is high

## Operation
- Address split with defaults: word [3:2], index [9:4], tag [31:10] (22 bits). Widths are derived from the parameters.
- Per line: valid bit, tag, LINE_WORDS data words.
- Hit = valid[index] and tag match, and the FSM is in IDLE. Instr1_2IF and Miss_STALL are combinational from the address.
- FSM states: IDLE and FILL.
- IDLE:
  - On a miss, latch the line address into Mem_addr, clear beat_cnt, set Mem_req, and go to FILL.
  - Miss_STALL is high in the miss cycle.
- FILL:
  - Miss_STALL is held high.
  - Each Mem_valid beat writes Mem_data into word[beat_cnt] of the latched index, then beat_cnt increments.
  - On the beat where beat_cnt = LINE_WORDS-1: write the tag, set valid (unless squashed), clear Mem_req, and return to IDLE.
- Fetch address change during FILL (for example, a redirect while stalled): ignored. The latched fill completes, and lookup resumes in IDLE with whatever address is current.
- A refill overwrites the victim line unconditionally. Its valid bit is cleared when FILL is entered, so a partial line never hits.
- Flush:
  - In IDLE: clears all valid bits at the edge.
  - During FILL: clears all valid bits and sets a squash flag. The fill still drains all beats so the memory protocol stays intact, but the line is not marked valid. The squash flag clears on the return to IDLE.
- Flush coincident with a miss in IDLE: flush takes effect, and the fill starts normally with no squash.
- Mem_valid while Mem_req is low is ignored.

## Timing
- Reset values:
  - Mem_req=0, Mem_addr=0, state IDLE, beat_cnt=0, squash=0, all valid bits 0.
  - With all lines invalid, Miss_STALL=1 and Instr1_2IF=0.
- Data and tag arrays are not reset.
- Hit latency: 0 cycles; the result is valid in the same cycle the address is presented.
- Miss, with memory returning one beat per cycle from the first Mem_req cycle:
  - Miss detected in cycle N; Mem_req is high in cycles N+1..N+LINE_WORDS.
  - The last beat is written at the end of N+LINE_WORDS.
  - The hit appears in N+LINE_WORDS+1, so stall cycles = LINE_WORDS+1.
- Memory gaps (Mem_valid low) extend the stall one cycle per gap cycle.
- Mem_req falls in the cycle after the last beat. The memory side must not send beats beyond LINE_WORDS.
- RESET asserted mid-fill: the fill is abandoned immediately, Mem_req drops asynchronously, and all lines are invalid. The memory side must tolerate an abandoned request.

## Structure
- Shared include icache_defs: default LINE_WORDS/NUM_LINES, derived field widths (WORD_BITS, INDEX_BITS, TAG_BITS), FSM state encodings.
- Sub-module icache_data_array: NUM_LINES×LINE_WORDS×32 storage, one write port (index, word, data, we) and one asynchronous read port. Tag and valid storage stays in icache.

## Test plan
- Cold start: after reset, address 0xBFC00000 -> Miss_STALL=1 and Mem_addr=0xBFC00000 with Mem_req high from the next cycle. Send four beats 0x11,0x22,0x33,0x44 -> next cycle Instr1_2IF=0x11 with Miss_STALL=0. Addresses 0xBFC00004/08/0C then hit with 0x22/0x33/0x44.
- Conflict: after filling 0xBFC00000, fetching 0xBFC00400 (same index, different tag) -> miss and refill. A subsequent fetch of 0xBFC00000 misses again.
- Gapped memory: Mem_valid pattern 1,0,0,1,1,0,1 -> exactly 4 writes, stall lasts 8 cycles, line correct.
- Address change mid-fill: switch to 0x80000020 during the fill of 0xBFC00010 -> the 0xBFC00010 line completes and becomes valid, then 0x80000020 misses and starts its own fill.
- Flush: Flush in IDLE -> next fetch of a previously hit address misses. Flush during the 2nd beat -> four beats still consumed, Mem_req drops, and the same address misses again afterwards.
- Reset on the 3rd beat -> Mem_req=0 immediately. After release, the formerly filled line misses.

Source files
------------

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg: default geometry, derived field widths and FSM state encoding
// Revision: 1.0
// ============================================================================
package icache_pkg;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;

    localparam int DEF_WORD_BITS  = $clog2(DEF_LINE_WORDS);
    localparam int DEF_INDEX_BITS = $clog2(DEF_NUM_LINES);
    localparam int DEF_TAG_BITS   = 32 - DEF_INDEX_BITS - DEF_WORD_BITS - 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// icache_if: fetch-side lookup port plus line-refill memory port
// Revision: 1.0
// ============================================================================
interface icache_if;

    logic [31:0] Instr_address_fIF;
    logic [31:0] Instr1_2IF;
    logic        Miss_STALL;
    logic        Flush;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_data;
    logic        Mem_valid;

    // master = fetch stage + memory system, slave = the cache
    modport master (
        output Instr_address_fIF, Flush, Mem_data, Mem_valid,
        input  Instr1_2IF, Miss_STALL, Mem_req, Mem_addr
    );

    modport slave (
        input  Instr_address_fIF, Flush, Mem_data, Mem_valid,
        output Instr1_2IF, Miss_STALL, Mem_req, Mem_addr
    );

endinterface
`default_nettype wire

// File: rtl/icache_data_array.sv
`default_nettype none
// ============================================================================
// icache_data_array: line data storage, one write port, one async read port
// Revision: 1.0
// ============================================================================
module icache_data_array #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [$clog2(NUM_LINES)-1:0]  widx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
    input  logic [31:0]                   wdata_i,
    input  logic [$clog2(NUM_LINES)-1:0]  ridx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
    output logic [31:0]                   rdata_o
);

    logic [31:0] mem_q [NUM_LINES][LINE_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[widx_i][wword_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i][rword_i];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// icache: direct-mapped instruction cache, zero-latency hit, stall-and-refill
// Revision: 1.0
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic    CLK,
    input  logic    RESET,
    icache_if.slave bus
);

    localparam int WORD_BITS  = $clog2(LINE_WORDS);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int OFF_BITS   = WORD_BITS + 2;
    localparam int TAG_LSB    = OFF_BITS + INDEX_BITS;
    localparam int TAG_BITS   = 32 - TAG_LSB;
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

    state_e                  state_q, state_d;
    logic [WORD_BITS-1:0]    beat_q, beat_d;
    logic                    squash_q, squash_d;
    logic                    req_q, req_d;
    logic [31:0]             maddr_q, maddr_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [TAG_BITS-1:0]     tag_q [NUM_LINES];

    logic [WORD_BITS-1:0]    addr_word;
    logic [INDEX_BITS-1:0]   addr_idx;
    logic [TAG_BITS-1:0]     addr_tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]     fill_tag;
    logic                    hit;
    logic                    data_we;
    logic                    tag_we;
    logic [31:0]             rdata;
    logic                    unused_addr_bits;

    assign addr_word = bus.Instr_address_fIF[OFF_BITS-1:2];
    assign addr_idx  = bus.Instr_address_fIF[TAG_LSB-1:OFF_BITS];
    assign addr_tag  = bus.Instr_address_fIF[31:TAG_LSB];
    assign fill_idx  = maddr_q[TAG_LSB-1:OFF_BITS];
    assign fill_tag  = maddr_q[31:TAG_LSB];
    assign unused_addr_bits = ^{bus.Instr_address_fIF[1:0], maddr_q[OFF_BITS-1:0]};

    // Lookup is suppressed while a fill is in flight so a redirect cannot hit mid-refill.
    assign hit = (state_q == ST_IDLE) && valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

    assign bus.Instr1_2IF = hit ? rdata : 32'h0;
    assign bus.Miss_STALL = ~hit;
    assign bus.Mem_req    = req_q;
    assign bus.Mem_addr   = maddr_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        squash_d = squash_q;
        req_d    = req_q;
        maddr_d  = maddr_q;
        valid_d  = valid_q;
        data_we  = 1'b0;
        tag_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Flush) begin
                    valid_d = '0;
                end
                if (!hit) begin
                    state_d           = ST_FILL;
                    maddr_d           = {bus.Instr_address_fIF[31:OFF_BITS], {OFF_BITS{1'b0}}};
                    beat_d            = '0;
                    squash_d          = 1'b0;
                    req_d             = 1'b1;
                    valid_d[addr_idx] = 1'b0;
                end
            end
            ST_FILL: begin
                if (bus.Flush) begin
                    valid_d  = '0;
                    squash_d = 1'b1;
                end
                if (bus.Mem_valid && req_q) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tag_we = 1'b1;
                        // A flush on the final beat squashes the line just like an earlier one.
                        if (!(squash_q || bus.Flush)) begin
                            valid_d[fill_idx] = 1'b1;
                        end
                        squash_d = 1'b0;
                        req_d    = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            maddr_q  <= 32'h0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            maddr_q  <= maddr_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_we) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

    icache_data_array #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_data_array (
        .clk_i   (CLK),
        .we_i    (data_we),
        .widx_i  (fill_idx),
        .wword_i (beat_q),
        .wdata_i (bus.Mem_data),
        .ridx_i  (addr_idx),
        .rword_i (addr_word),
        .rdata_o (rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// tb_icache: directed scenarios plus randomized traffic against a line-level model
// Revision: 1.0
// ============================================================================
module tb_icache;
    import icache_pkg::*;

    localparam int LW         = DEF_LINE_WORDS;
    localparam int NL         = DEF_NUM_LINES;
    localparam int LINE_BYTES = LW * 4;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    icache_if bus ();

    icache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    bit          m_valid [NL];
    logic [31:0] m_tag   [NL];
    logic [31:0] m_data  [NL][LW];
    bit          m_filling;
    bit          m_squash;
    int          m_beats;
    logic [31:0] m_req_addr;

    function automatic int idx_of(logic [31:0] a);
        return int'((a / LINE_BYTES) % NL);
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a / 4) % LW);
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] a);
        return a / (LINE_BYTES * NL);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_filling  = 1'b0;
        m_squash   = 1'b0;
        m_beats    = 0;
        m_req_addr = 32'h0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic [31:0] a, input bit fl, input bit mv,
                         input logic [31:0] md, output bit stall);
        int  i;
        int  fi;
        bit  hit;
        bus.Instr_address_fIF = a;
        bus.Flush             = fl;
        bus.Mem_valid         = mv;
        bus.Mem_data          = md;
        #1;
        i   = idx_of(a);
        hit = !m_filling && m_valid[i] && (m_tag[i] == tag_of(a));
        check_eq("instr", bus.Instr1_2IF, hit ? m_data[i][word_of(a)] : 32'h0);
        check_eq("stall", 32'(bus.Miss_STALL), 32'(!hit));
        check_eq("mem_req", 32'(bus.Mem_req), 32'(m_filling));
        check_eq("mem_addr", bus.Mem_addr, m_req_addr);
        stall = bus.Miss_STALL;
        if (!m_filling) begin
            if (fl) foreach (m_valid[k]) m_valid[k] = 1'b0;
            if (!hit) begin
                m_filling  = 1'b1;
                m_squash   = 1'b0;
                m_beats    = 0;
                m_req_addr = a - (a % LINE_BYTES);
                m_valid[i] = 1'b0;
            end
        end else begin
            fi = idx_of(m_req_addr);
            if (fl) begin
                foreach (m_valid[k]) m_valid[k] = 1'b0;
                m_squash = 1'b1;
            end
            if (mv) begin
                m_data[fi][m_beats] = md;
                m_beats++;
                if (m_beats == LW) begin
                    m_tag[fi]   = tag_of(m_req_addr);
                    m_valid[fi] = !m_squash;
                    m_filling   = 1'b0;
                    m_squash    = 1'b0;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Explicit expectations from the scenario, then one idle-memory cycle through the model.
    task automatic probe(input string nm, input logic [31:0] a, input logic [31:0] ins,
                         input bit st, input bit rq, input logic [31:0] ma);
        bit s;
        bus.Instr_address_fIF = a;
        bus.Flush             = 1'b0;
        bus.Mem_valid         = 1'b0;
        #1;
        check_eq({nm, "_instr"}, bus.Instr1_2IF, ins);
        check_eq({nm, "_stall"}, 32'(bus.Miss_STALL), 32'(st));
        check_eq({nm, "_req"}, 32'(bus.Mem_req), 32'(rq));
        check_eq({nm, "_maddr"}, bus.Mem_addr, ma);
        cycle(a, 1'b0, 1'b0, $urandom, s);
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] base, input logic [31:0] step);
        bit s;
        cycle(a, 1'b0, 1'b0, 32'h0, s);
        for (int b = 0; b < LW; b++) cycle(a, 1'b0, 1'b1, base + step * 32'(b), s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s;
        int          stalls;
        logic [31:0] cur;
        bit          gaps [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [31:0] dgap;

        bus.Instr_address_fIF = 32'h0;
        bus.Flush             = 1'b0;
        bus.Mem_valid         = 1'b0;
        bus.Mem_data          = 32'h0;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        bus.Instr_address_fIF = 32'hBFC0_0000;
        #1;
        check_eq("rst_req", 32'(bus.Mem_req), 32'h0);
        check_eq("rst_addr", bus.Mem_addr, 32'h0);
        check_eq("rst_stall", 32'(bus.Miss_STALL), 32'h1);
        check_eq("rst_instr", bus.Instr1_2IF, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;

        // Cold start
        probe("cold_miss", 32'hBFC0_0000, 32'h0, 1'b1, 1'b0, 32'h0);
        bus.Instr_address_fIF = 32'hBFC0_0000;
        #1;
        check_eq("cold_req", 32'(bus.Mem_req), 32'h1);
        check_eq("cold_maddr", bus.Mem_addr, 32'hBFC0_0000);
        for (int b = 0; b < LW; b++) cycle(32'hBFC0_0000, 1'b0, 1'b1, 32'h11 * 32'(b + 1), s);
        probe("cold_w0", 32'hBFC0_0000, 32'h11, 1'b0, 1'b0, 32'hBFC0_0000);
        probe("cold_w1", 32'hBFC0_0004, 32'h22, 1'b0, 1'b0, 32'hBFC0_0000);
        probe("cold_w2", 32'hBFC0_0008, 32'h33, 1'b0, 1'b0, 32'hBFC0_0000);
        probe("cold_w3", 32'hBFC0_000C, 32'h44, 1'b0, 1'b0, 32'hBFC0_0000);

        // Conflict on the same index
        fill(32'hBFC0_0400, 32'h5500_0000, 32'h1);
        probe("conf_new", 32'hBFC0_0404, 32'h5500_0001, 1'b0, 1'b0, 32'hBFC0_0400);
        probe("conf_old", 32'hBFC0_0000, 32'h0, 1'b1, 1'b0, 32'hBFC0_0400);
        for (int b = 0; b < LW; b++) cycle(32'hBFC0_0000, 1'b0, 1'b1, 32'h11 * 32'(b + 1), s);

        // Gapped memory: 1,0,0,1,1,0,1
        stalls = 0;
        dgap   = 32'hC0DE_0000;
        cycle(32'hBFC0_0020, 1'b0, 1'b0, 32'h0, s);
        stalls += int'(s);
        foreach (gaps[g]) begin
            cycle(32'hBFC0_0020, 1'b0, gaps[g], dgap, s);
            stalls += int'(s);
            if (gaps[g]) dgap++;
        end
        check_eq("gap_stalls", 32'(stalls), 32'd8);
        probe("gap_w3", 32'hBFC0_002C, 32'hC0DE_0003, 1'b0, 1'b0, 32'hBFC0_0020);

        // Redirect during fill
        cycle(32'hBFC0_0010, 1'b0, 1'b0, 32'h0, s);
        cycle(32'hBFC0_0010, 1'b0, 1'b1, 32'hA0, s);
        cycle(32'hBFC0_0010, 1'b0, 1'b1, 32'hA1, s);
        cycle(32'h8000_0020, 1'b0, 1'b1, 32'hA2, s);
        cycle(32'h8000_0020, 1'b0, 1'b1, 32'hA3, s);
        probe("redir_miss", 32'h8000_0020, 32'h0, 1'b1, 1'b0, 32'hBFC0_0010);
        probe("redir_fill", 32'hBFC0_0014, 32'h0, 1'b1, 1'b1, 32'h8000_0020);
        for (int b = 0; b < LW; b++) cycle(32'h8000_0020, 1'b0, 1'b1, 32'hB0 + 32'(b), s);
        probe("redir_old", 32'hBFC0_0014, 32'hA1, 1'b0, 1'b0, 32'h8000_0020);

        // Flush in IDLE, then flush during the 2nd beat
        probe("fl_pre", 32'hBFC0_0004, 32'h22, 1'b0, 1'b0, 32'h8000_0020);
        cycle(32'hBFC0_0004, 1'b1, 1'b0, 32'h0, s);
        probe("fl_idle", 32'hBFC0_0004, 32'h0, 1'b1, 1'b0, 32'h8000_0020);
        cycle(32'hBFC0_0004, 1'b0, 1'b1, 32'h1, s);
        cycle(32'hBFC0_0004, 1'b1, 1'b1, 32'h2, s);
        cycle(32'hBFC0_0004, 1'b0, 1'b1, 32'h3, s);
        cycle(32'hBFC0_0004, 1'b0, 1'b1, 32'h4, s);
        probe("fl_squash", 32'hBFC0_0004, 32'h0, 1'b1, 1'b0, 32'hBFC0_0000);

        // Reset on the 3rd beat of an unrelated fill
        for (int b = 0; b < LW; b++) cycle(32'hBFC0_0004, 1'b0, 1'b1, 32'h11 * 32'(b + 1), s);
        probe("rs_pre", 32'hBFC0_0008, 32'h33, 1'b0, 1'b0, 32'hBFC0_0000);
        cycle(32'h1234_5040, 1'b0, 1'b0, 32'h0, s);
        cycle(32'h1234_5040, 1'b0, 1'b1, 32'h7, s);
        cycle(32'h1234_5040, 1'b0, 1'b1, 32'h8, s);
        bus.Mem_valid = 1'b1;
        bus.Mem_data  = 32'h9;
        #2;
        RESET = 1'b0;
        #1;
        check_eq("rs_req_async", 32'(bus.Mem_req), 32'h0);
        check_eq("rs_stall", 32'(bus.Miss_STALL), 32'h1);
        @(posedge CLK);
        @(negedge CLK);
        bus.Mem_valid = 1'b0;
        model_reset();
        RESET = 1'b1;
        probe("rs_after", 32'hBFC0_0008, 32'h0, 1'b1, 1'b0, 32'h0);

        // Randomized traffic over a small address pool to force hits, conflicts and flushes
        cur = 32'hBFC0_0008;
        s   = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            bit fl;
            bit mv;
            if ((!s && $urandom_range(0, 9) < 7) || (s && $urandom_range(0, 9) == 0)) begin
                if ($urandom_range(0, 1) == 1) cur = cur + 32'h4;
                else cur = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
                         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            end
            fl = ($urandom_range(0, 39) == 0);
            mv = m_filling ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 4) == 0);
            cycle(cur, fl, mv, $urandom, s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
